// File: rtl/waveform_stream_loader.sv
// Load-port initiator for waveform_stream: requests the store, then streams exactly wf_len
// upstream samples through a registered 2-entry skid buffer with tlast on the final beat.
module waveform_stream_loader #(
    parameter int DATA_WIDTH  = 32,
    parameter int LEN_WIDTH   = 16,
    parameter int REQ_TIMEOUT = 1024
) (
    input  logic                    CLOCK,
    input  logic                    RESET,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    wf_len,
    input  logic [95:0]             wf_param_hi,
    output logic [127:0]            waveform_parameters,
    output logic                    init_wf_write,
    input  logic                    wf_write_ready,
    input  logic [DATA_WIDTH-1:0]   src_tdata,
    input  logic                    src_tvalid,
    output logic                    src_tready,
    output logic [DATA_WIDTH-1:0]   wfin_axis_tdata,
    output logic                    wfin_axis_tvalid,
    output logic                    wfin_axis_tlast,
    output logic [DATA_WIDTH/8-1:0] wfin_axis_tkeep,
    input  logic                    wfin_axis_tready,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int TO_W = (REQ_TIMEOUT > 1) ? $clog2(REQ_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = (REQ_TIMEOUT > 1) ? TO_W'(REQ_TIMEOUT - 1) : '0;

    logic [1:0]            r_state;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_src_cnt;
    logic [95:0]           r_param_hi;
    logic [TO_W-1:0]       r_to_cnt;
    logic                  r_error;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_skid_valid;
    logic                  r_skid_last;

    logic w_src_ready;
    logic w_src_fire;
    logic w_src_last;
    logic w_out_fire;
    logic w_final;
    logic w_timeout;
    logic [31:0] w_len_ext;

    // Source side only looks at registered state, so wfin_axis_tready never reaches src_tready.
    assign w_src_ready = (r_state == S_STREAM) && !r_skid_valid && (r_src_cnt < r_len);
    assign w_src_fire  = src_tvalid && w_src_ready;
    assign w_src_last  = (r_src_cnt == (r_len - LEN_WIDTH'(1)));
    assign w_out_fire  = r_out_valid && wfin_axis_tready;
    assign w_final     = w_out_fire && r_out_last;
    assign w_timeout   = (REQ_TIMEOUT != 0) && (r_to_cnt == TO_LAST);
    assign w_len_ext   = 32'(r_len);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_src_cnt    <= '0;
            r_param_hi   <= '0;
            r_to_cnt     <= '0;
            r_error      <= 1'b0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_last  <= 1'b0;
        end else begin
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (wf_len == '0) begin
                            r_error <= 1'b1;
                        end else begin
                            r_state    <= S_REQ;
                            r_len      <= wf_len;
                            r_param_hi <= wf_param_hi;
                            r_to_cnt   <= '0;
                            r_src_cnt  <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (wf_write_ready) begin
                        r_state <= S_STREAM;
                    end else if (w_timeout) begin
                        r_state    <= S_IDLE;
                        r_error    <= 1'b1;
                        r_len      <= '0;
                        r_param_hi <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_STREAM: begin
                    if (w_final) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_src_fire) begin
                r_src_cnt <= r_src_cnt + LEN_WIDTH'(1);
            end

            // Output register refills from the skid entry first; a stalled output parks the new beat.
            if (w_out_fire || !r_out_valid) begin
                if (r_skid_valid) begin
                    r_out_data   <= r_skid_data;
                    r_out_last   <= r_skid_last;
                    r_out_valid  <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else begin
                    r_out_valid <= w_src_fire;
                    r_out_last  <= w_src_fire && w_src_last;
                    if (w_src_fire) begin
                        r_out_data <= src_tdata;
                    end
                end
            end else if (w_src_fire) begin
                r_skid_data  <= src_tdata;
                r_skid_last  <= w_src_last;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign waveform_parameters = {r_param_hi, w_len_ext};
    assign init_wf_write       = (r_state == S_REQ);
    assign src_tready          = w_src_ready;
    assign wfin_axis_tdata     = r_out_data;
    assign wfin_axis_tvalid    = r_out_valid;
    assign wfin_axis_tlast     = r_out_last;
    assign wfin_axis_tkeep     = {(DATA_WIDTH/8){r_out_valid}};
    assign busy                = (r_state != S_IDLE);
    assign done                = (r_state == S_DONE);
    assign error               = r_error;

endmodule

// File: tb/tb_waveform_stream_loader.sv
// Scoreboard bench for waveform_stream_loader: loads push expected beats, a negedge monitor pops them.
module tb_waveform_stream_loader;

    logic         CLOCK = 1'b0;
    logic         RESET = 1'b1;
    logic         start = 1'b0;
    logic [15:0]  wf_len = '0;
    logic [95:0]  wf_param_hi = '0;
    logic [127:0] waveform_parameters;
    logic         init_wf_write;
    logic         wf_write_ready = 1'b0;
    logic [31:0]  src_idx = '0;
    logic         src_tvalid = 1'b0;
    logic         src_tready;
    logic [31:0]  wfin_axis_tdata;
    logic         wfin_axis_tvalid;
    logic         wfin_axis_tlast;
    logic [3:0]   wfin_axis_tkeep;
    logic         wfin_axis_tready = 1'b0;
    logic         busy, done, error;

    typedef struct packed { logic [31:0] d; logic l; } beat_t;
    beat_t exp_q[$];

    int total = 0, bad = 0;
    int done_cnt = 0, err_cnt = 0, beats_seen = 0;
    int rdy_mode = 0, phase = 0;
    bit src_rand = 0;
    logic [127:0] exp_params;

    waveform_stream_loader #(.DATA_WIDTH(32), .LEN_WIDTH(16), .REQ_TIMEOUT(16)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .start(start), .wf_len(wf_len), .wf_param_hi(wf_param_hi),
        .waveform_parameters(waveform_parameters), .init_wf_write(init_wf_write),
        .wf_write_ready(wf_write_ready), .src_tdata(src_idx), .src_tvalid(src_tvalid),
        .src_tready(src_tready), .wfin_axis_tdata(wfin_axis_tdata), .wfin_axis_tvalid(wfin_axis_tvalid),
        .wfin_axis_tlast(wfin_axis_tlast), .wfin_axis_tkeep(wfin_axis_tkeep),
        .wfin_axis_tready(wfin_axis_tready), .busy(busy), .done(done), .error(error)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick;
        @(posedge CLOCK);
        #1;
    endtask

    // Upstream source (incrementing counter) and downstream ready pattern.
    initial begin
        logic fire;
        forever begin
            @(posedge CLOCK);
            fire = src_tvalid && src_tready;
            #1;
            if (fire) src_idx = src_idx + 32'd1;
            src_tvalid = src_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            phase++;
            case (rdy_mode)
                0: wfin_axis_tready = 1'b1;
                default: wfin_axis_tready = ((phase % 4) == 0) || ((phase % 4) == 3);
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted beat and checks stall stability.
    logic        prev_valid = 0, prev_ready = 0, prev_last = 0, prev_rst = 1;
    logic [31:0] prev_data = '0;
    always @(negedge CLOCK) begin
        beat_t e;
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (prev_valid && !prev_ready && !prev_rst && !RESET) begin
            check("stall_valid", wfin_axis_tvalid, 1);
            check("stall_data", wfin_axis_tdata, prev_data);
            check("stall_last", wfin_axis_tlast, prev_last);
        end
        if (wfin_axis_tvalid) check("tkeep", wfin_axis_tkeep, 4'hF);
        if (wfin_axis_tvalid && wfin_axis_tready) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got data %0h, no beat expected", wfin_axis_tdata);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", wfin_axis_tdata, e.d);
                check("beat_last", wfin_axis_tlast, e.l);
            end
        end
        prev_valid = wfin_axis_tvalid;
        prev_ready = wfin_axis_tready;
        prev_data  = wfin_axis_tdata;
        prev_last  = wfin_axis_tlast;
        prev_rst   = RESET;
    end

    task automatic begin_load(input int len, input logic [95:0] hi, input int gdly);
        beat_t b;
        src_idx = '0;
        for (int k = 0; k < len; k++) begin
            b.d = 32'(k);
            b.l = (k == len - 1);
            exp_q.push_back(b);
        end
        exp_params = {hi, 32'(len)};
        start = 1'b1; wf_len = 16'(len); wf_param_hi = hi;
        tick;
        start = 1'b0;
        @(negedge CLOCK);
        check("req_init", init_wf_write, 1);
        check("req_busy", busy, 1);
        check("req_params", waveform_parameters, exp_params);
        for (int c = 0; c < gdly; c++) tick;
        wf_write_ready = 1'b1;
        tick;
        wf_write_ready = 1'b0;
        @(negedge CLOCK);
        check("init_dropped", init_wf_write, 0);
    endtask

    task automatic finish_load(input int len);
        int d0;
        bit ok;
        d0 = done_cnt;
        ok = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge CLOCK);
            if (done) begin ok = 1; break; end
        end
        check("done_seen", ok, 1);
        if (ok) check("busy_in_done", busy, 1);
        @(negedge CLOCK);
        check("busy_after", busy, 0);
        check("done_width", done, 0);
        check("queue_drained", exp_q.size(), 0);
        check("src_taken", src_idx, len);
        check("done_count", done_cnt - d0, 1);
    endtask

    task automatic wait_beats(input int n);
        int b0;
        b0 = beats_seen;
        for (int c = 0; c < 2000; c++) begin
            @(negedge CLOCK);
            if (beats_seen - b0 >= n) break;
        end
        check("beat_progress", (beats_seen - b0 >= n), 1);
    endtask

    initial begin
        int e0, d0, n;
        // Reset state
        RESET = 1'b1;
        repeat (3) tick;
        RESET = 1'b0;
        @(negedge CLOCK);
        check("rst_params", waveform_parameters, 0);
        check("rst_tkeep", wfin_axis_tkeep, 0);
        check("rst_tvalid", wfin_axis_tvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_ctrl", {init_wf_write, done, error, wfin_axis_tlast}, 0);

        // Full-rate 128-sample load, grant after 3 request cycles
        begin_load(128, 96'h00000000_00000600_00000001, 2);
        check("param_word", waveform_parameters, 128'h00000000_00000600_00000001_00000080);
        finish_load(128);

        // Same load with stalling sink and bursty source
        src_rand = 1; rdy_mode = 1;
        begin_load(128, 96'h00000000_00000600_00000001, 2);
        finish_load(128);
        @(negedge CLOCK);
        check("src_ready_idle", src_tready, 0);
        src_rand = 0; rdy_mode = 0;

        // Zero length rejects, single beat carries tlast
        e0 = err_cnt;
        tick;
        start = 1'b1; wf_len = 16'd0;
        tick;
        start = 1'b0;
        @(negedge CLOCK);
        check("zero_err", error, 1);
        check("zero_init", init_wf_write, 0);
        check("zero_busy", busy, 0);
        @(negedge CLOCK);
        check("zero_err_width", error, 0);
        check("zero_err_count", err_cnt - e0, 1);
        begin_load(1, 96'h1234, 0);
        finish_load(1);

        // Request timeout after 16 cycles without grant
        tick;
        start = 1'b1; wf_len = 16'd4; wf_param_hi = 96'hABC;
        tick;
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLOCK);
            if (!init_wf_write) break;
            n++;
        end
        check("timeout_req_cycles", n, 16);
        check("timeout_err", error, 1);
        check("timeout_busy", busy, 0);
        check("timeout_params", waveform_parameters, 0);
        begin_load(8, 96'h55, 1);
        finish_load(8);

        // Reset in the middle of a load
        d0 = done_cnt;
        begin_load(128, 96'h77, 0);
        wait_beats(40);
        RESET = 1'b1;
        @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        @(negedge CLOCK);
        check("mid_rst_tvalid", wfin_axis_tvalid, 0);
        check("mid_rst_tdata", wfin_axis_tdata, 0);
        check("mid_rst_params", waveform_parameters, 0);
        check("mid_rst_ctrl", {busy, done, error, init_wf_write, wfin_axis_tlast, src_tready}, 0);
        exp_q.delete();
        repeat (5) @(negedge CLOCK);
        check("mid_rst_no_done", done_cnt - d0, 0);
        begin_load(128, 96'h88, 1);
        finish_load(128);

        // Start pulsed mid-stream is ignored
        begin_load(20, 96'h99, 0);
        wait_beats(5);
        start = 1'b1; wf_len = 16'd5; wf_param_hi = '1;
        @(negedge CLOCK);
        start = 1'b0;
        check("ignored_start_params", waveform_parameters, exp_params);
        finish_load(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
